// File: rtl/radix2_div_engine.sv
// Iterative restoring divider: one quotient bit per cycle, sign fixup at completion.
// Optional DIV_EARLY_OUT_EN skips the iterations when divisor > dividend (divisor != 0).
module radix2_div_engine #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             div_begin,
   input  logic             div_sign,
   input  logic             div_dividend_sign,
   input  logic [WIDTH-1:0] div_dividend,
   input  logic [WIDTH-1:0] div_divisor,
   output logic [WIDTH-1:0] div_quotient,
   output logic [WIDTH-1:0] div_remainder,
   output logic             div_done,
   output logic             div_busy
);

   localparam int unsigned CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] rem, rem_nxt;
   logic [WIDTH-1:0] quo, quo_nxt;
   logic [WIDTH-1:0] dvs, dvs_nxt;
   logic             q_neg, q_neg_nxt;
   logic             r_neg, r_neg_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [WIDTH-1:0] quotient_nxt, remainder_nxt;
   logic             done_nxt, busy_nxt;
   logic [WIDTH:0]   rem_sh;
   logic             early_c;

   // Shifted partial remainder kept one bit wider so the compare never loses a carry
   assign rem_sh = {rem, quo[WIDTH-1]};

`ifdef DIV_EARLY_OUT_EN
   assign early_c = (div_divisor != '0) && (div_divisor > div_dividend);
`else
   assign early_c = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (div_begin) state_nxt = early_c ? FIN : RUN;
         RUN:     if (cnt == LAST_ITER) state_nxt = FIN;
         FIN:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath and registered-output next values
   always_comb begin
      rem_nxt       = rem;
      quo_nxt       = quo;
      dvs_nxt       = dvs;
      q_neg_nxt     = q_neg;
      r_neg_nxt     = r_neg;
      cnt_nxt       = cnt;
      quotient_nxt  = div_quotient;
      remainder_nxt = div_remainder;
      done_nxt      = 1'b0;
      busy_nxt      = (state == RUN) || (state == FIN);
      case (state)
         IDLE: begin
            if (div_begin) begin
               dvs_nxt   = div_divisor;
               q_neg_nxt = div_sign;
               r_neg_nxt = div_dividend_sign;
               cnt_nxt   = '0;
               if (early_c) begin
                  quo_nxt = '0;
                  rem_nxt = div_dividend;
               end else begin
                  quo_nxt = div_dividend;
                  rem_nxt = '0;
               end
            end
         end
         RUN: begin
            if (rem_sh >= {1'b0, dvs}) begin
               rem_nxt = WIDTH'(rem_sh - {1'b0, dvs});
               quo_nxt = {quo[WIDTH-2:0], 1'b1};
            end else begin
               rem_nxt = rem_sh[WIDTH-1:0];
               quo_nxt = {quo[WIDTH-2:0], 1'b0};
            end
            cnt_nxt = cnt + CNT_W'(1);
         end
         FIN: begin
            quotient_nxt  = q_neg ? -quo : quo;
            remainder_nxt = r_neg ? -rem : rem;
            done_nxt      = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rem           <= '0;
         quo           <= '0;
         dvs           <= '0;
         q_neg         <= 1'b0;
         r_neg         <= 1'b0;
         cnt           <= '0;
         div_quotient  <= '0;
         div_remainder <= '0;
         div_done      <= 1'b0;
         div_busy      <= 1'b0;
      end else begin
         rem           <= rem_nxt;
         quo           <= quo_nxt;
         dvs           <= dvs_nxt;
         q_neg         <= q_neg_nxt;
         r_neg         <= r_neg_nxt;
         cnt           <= cnt_nxt;
         div_quotient  <= quotient_nxt;
         div_remainder <= remainder_nxt;
         div_done      <= done_nxt;
         div_busy      <= busy_nxt;
      end
   end

endmodule

// File: tb/tb_radix2_div_engine.sv
// Bench for radix2_div_engine: arithmetic divide model checked every cycle plus directed literals.
// Honours DIV_EARLY_OUT_EN for the expected latency of small-over-large divides.
module tb_radix2_div_engine;

   localparam int unsigned WIDTH = 32;
   localparam int FULL_LAT = WIDTH + 1;
`ifdef DIV_EARLY_OUT_EN
   localparam int EARLY_LAT = 1;
`else
   localparam int EARLY_LAT = FULL_LAT;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        div_begin = 1'b0;
   logic        div_sign = 1'b0;
   logic        div_dividend_sign = 1'b0;
   logic [31:0] div_dividend = '0;
   logic [31:0] div_divisor = '0;
   logic [31:0] div_quotient;
   logic [31:0] div_remainder;
   logic        div_done;
   logic        div_busy;

   radix2_div_engine #(.WIDTH(WIDTH)) dut (
      .clk               (clk),
      .rst               (rst),
      .div_begin         (div_begin),
      .div_sign          (div_sign),
      .div_dividend_sign (div_dividend_sign),
      .div_dividend      (div_dividend),
      .div_divisor       (div_divisor),
      .div_quotient      (div_quotient),
      .div_remainder     (div_remainder),
      .div_done          (div_done),
      .div_busy          (div_busy)
   );

   always #5 clk = ~clk;

   int   cyc = 0;
   logic rst_q = 1'b0;
   always @(posedge clk) begin
      cyc   <= cyc + 1;
      rst_q <= rst;
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @edge %0d: got %h expected %h", nm, cyc, act, exp);
      end
   endtask

   // Model state: one outstanding operation plus the held result pair
   bit          active = 1'b0;
   bit          chk_en = 1'b0;
   int          pend_t = 0;
   int          pend_done = 0;
   logic [31:0] pend_q = '0;
   logic [31:0] pend_r = '0;
   logic [31:0] held_q = '0;
   logic [31:0] held_r = '0;
   bit          exp_done, exp_busy;

   function automatic int model_lat(input logic [31:0] dvd, input logic [31:0] dvs);
      bit skip;
      skip = (dvs != 0) && (dvs > dvd);
`ifndef DIV_EARLY_OUT_EN
      skip = 1'b0;
`endif
      return skip ? 1 : FULL_LAT;
   endfunction

   // Called when the next rising edge is known to latch a begin
   task automatic issue(input logic [31:0] dvd, input logic [31:0] dvs, input logic s, input logic ds);
      logic [31:0] qm, rm;
      qm        = (dvs == 0) ? 32'hFFFF_FFFF : dvd / dvs;
      rm        = (dvs == 0) ? dvd : dvd % dvs;
      pend_q    = s  ? -qm : qm;
      pend_r    = ds ? -rm : rm;
      pend_t    = cyc + 1;
      pend_done = pend_t + model_lat(dvd, dvs);
      active    = 1'b1;
   endtask

   always @(negedge clk) begin
      if (rst_q) begin
         chk_en = 1'b1;
         active = 1'b0;
         held_q = '0;
         held_r = '0;
      end
      if (chk_en) begin
         exp_done = active && (cyc == pend_done);
         exp_busy = active && (cyc > pend_t) && (cyc <= pend_done);
         if (exp_done) begin
            held_q = pend_q;
            held_r = pend_r;
            active = 1'b0;
         end
         check("cyc_done", 32'(div_done), 32'(exp_done));
         check("cyc_busy", 32'(div_busy), 32'(exp_busy));
         check("cyc_quotient", div_quotient, held_q);
         check("cyc_remainder", div_remainder, held_r);
      end
   end

   task automatic tick();
      @(negedge clk);
      #2;
   endtask

   task automatic wait_done(input string nm, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < 60; i++) begin
         tick();
         if (div_done) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) check({nm, "_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic run_op(input string nm, input logic [31:0] dvd, input logic [31:0] dvs,
                         input logic s, input logic ds, input logic [31:0] eq,
                         input logic [31:0] er, input int elat);
      int t0;
      bit seen;
      tick();
      div_dividend = dvd; div_divisor = dvs; div_sign = s; div_dividend_sign = ds;
      div_begin = 1'b1;
      issue(dvd, dvs, s, ds);
      t0 = cyc + 1;
      tick();
      // Operand changes after latching must not matter
      div_begin = 1'b0;
      div_dividend = ~dvd; div_divisor = dvs ^ 32'h5A5A_0001;
      div_sign = ~s; div_dividend_sign = ~ds;
      wait_done(nm, seen);
      if (seen) begin
         check({nm, "_latency"}, 32'(cyc - t0), 32'(elat));
         check({nm, "_q"}, div_quotient, eq);
         check({nm, "_r"}, div_remainder, er);
      end
      tick();
      check({nm, "_q_held"}, div_quotient, eq);
      check({nm, "_r_held"}, div_remainder, er);
   endtask

   initial begin
      int t0, d1, d2, n_done;
      bit seen;
      tick(); tick(); tick();
      rst = 1'b0;
      check("reset_q", div_quotient, 32'd0);
      check("reset_r", div_remainder, 32'd0);
      check("reset_done", 32'(div_done), 32'd0);
      check("reset_busy", 32'(div_busy), 32'd0);

      run_op("basic",      32'd100,        32'd7,          1'b0, 1'b0, 32'd14,         32'd2,          FULL_LAT);
      run_op("neg_dvd",    32'd7,          32'd2,          1'b1, 1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  FULL_LAT);
      run_op("neg_dvs",    32'd7,          32'd2,          1'b1, 1'b0, 32'hFFFF_FFFD,  32'h0000_0001,  FULL_LAT);
      run_op("max_by_1",   32'hFFFF_FFFF,  32'd1,          1'b0, 1'b0, 32'hFFFF_FFFF,  32'd0,          FULL_LAT);
      run_op("max_by_msb", 32'hFFFF_FFFF,  32'h8000_0000,  1'b0, 1'b0, 32'd1,          32'h7FFF_FFFF,  FULL_LAT);
      run_op("small_big",  32'd3,          32'd10,         1'b0, 1'b0, 32'd0,          32'd3,          EARLY_LAT);
      run_op("neg_small",  32'd3,          32'd10,         1'b1, 1'b1, 32'd0,          32'hFFFF_FFFD,  EARLY_LAT);
      run_op("near_max",   32'hFFFF_FFFE,  32'hFFFF_FFFF,  1'b0, 1'b0, 32'd0,          32'hFFFF_FFFE,  EARLY_LAT);
      run_op("div_zero",   32'h1234_5678,  32'd0,          1'b0, 1'b0, 32'hFFFF_FFFF,  32'h1234_5678,  FULL_LAT);

      // Reset in the middle of a run: no done, outputs cleared
      tick();
      div_dividend = 32'd100; div_divisor = 32'd7; div_sign = 1'b0; div_dividend_sign = 1'b0;
      div_begin = 1'b1;
      issue(32'd100, 32'd7, 1'b0, 1'b0);
      t0 = cyc + 1;
      tick();
      div_begin = 1'b0;
      while (cyc < t0 + 9) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_q", div_quotient, 32'd0);
      check("midrst_r", div_remainder, 32'd0);
      check("midrst_busy", 32'(div_busy), 32'd0);
      n_done = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (div_done) n_done++;
      end
      check("midrst_no_done", 32'(n_done), 32'd0);
      run_op("after_rst", 32'd100, 32'd7, 1'b0, 1'b0, 32'd14, 32'd2, FULL_LAT);

      // Back-to-back: begin held across done restarts in the cycle after done
      tick();
      div_dividend = 32'd100; div_divisor = 32'd7; div_sign = 1'b0; div_dividend_sign = 1'b0;
      div_begin = 1'b1;
      issue(32'd100, 32'd7, 1'b0, 1'b0);
      wait_done("b2b_first", seen);
      d1 = cyc;
      check("b2b_first_q", div_quotient, 32'd14);
      check("b2b_first_r", div_remainder, 32'd2);
      div_dividend = 32'd9; div_divisor = 32'd4;
      issue(32'd9, 32'd4, 1'b0, 1'b0);
      tick();
      div_begin = 1'b0;
      wait_done("b2b_second", seen);
      d2 = cyc;
      if (seen) begin
         check("b2b_gap", 32'(d2 - d1), 32'd34);
         check("b2b_q", div_quotient, 32'd2);
         check("b2b_r", div_remainder, 32'd1);
      end
      tick(); tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
